// File: rtl/sd_cmd_rsp_rx.sv
// sd_cmd_rsp_rx: SD CMD-line response receiver.
// Waits for the start bit within the NCR window, shifts a 48- or 136-bit
// response in MSb first, checks CRC7 / transmission bit / end bit and
// presents the result over a valid/ready handshake.
// Build option: define SDHCI_RSP_LONG_EN to compile in the 136-bit R2 path.
module sd_cmd_rsp_rx #(
    parameter int unsigned TimeoutCycles = 64,
    parameter int unsigned CntWidth      = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clk_en_i,
    input  logic         start_i,
    input  logic         long_i,
    input  logic         check_crc_i,
    input  logic         abort_i,
    input  logic         cmd_i,
    output logic         busy_o,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [127:0] rsp_o,
    output logic [5:0]   index_o,
    output logic         timeout_err_o,
    output logic         crc_err_o,
    output logic         frame_err_o
);

`ifdef SDHCI_RSP_LONG_EN
    localparam int unsigned FrameW = 128;
`else
    localparam int unsigned FrameW = 48;
`endif

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        SHIFT      = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t              state, state_next;
    logic                long_q;
    logic                check_crc_q;
    logic                timeout_q;
    logic [FrameW-1:0]   frame;
    logic [6:0]          crc;
    logic [CntWidth-1:0] tcnt;
    logic [CntWidth-1:0] bcnt;
    logic                crc_en;
    logic                crc_fb;
    logic                timeout_hit;

`ifndef SDHCI_RSP_LONG_EN
    // Short-only build: no R2 path, the start-bit slot of the frame is never read.
    logic unused_bits;
    assign long_q      = 1'b0;
    assign unused_bits = ^{long_i, frame[47]};
`endif

    // bcnt holds the index of the last bit received; CRC covers bit indices
    // up to 46 (short; start bit is zero and cannot disturb a cleared CRC)
    // or 127 (long), down to 8.
    assign crc_en      = (bcnt >= CntWidth'(9)) && (!long_q || (bcnt <= CntWidth'(128)));
    assign crc_fb      = crc[6] ^ cmd_i;
    assign timeout_hit = (tcnt == CntWidth'(TimeoutCycles - 1));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start_i) state_next = WAIT_START;
            WAIT_START: if (clk_en_i) begin
                            if (!cmd_i)           state_next = SHIFT;
                            else if (timeout_hit) state_next = DONE;
                        end
            SHIFT:      if (clk_en_i && (bcnt == CntWidth'(1))) state_next = DONE;
            DONE:       if (rsp_ready_i) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
        if (abort_i) state_next = IDLE;
    end

    // Datapath: configuration latch, timeout/bit counters, frame shifter, CRC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
`ifdef SDHCI_RSP_LONG_EN
            long_q      <= 1'b0;
`endif
            check_crc_q <= 1'b0;
            timeout_q   <= 1'b0;
            frame       <= '0;
            crc         <= '0;
            tcnt        <= '0;
            bcnt        <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
`ifdef SDHCI_RSP_LONG_EN
                    long_q      <= long_i;
`endif
                    check_crc_q <= check_crc_i;
                    timeout_q   <= 1'b0;
                    frame       <= '0;
                    crc         <= '0;
                    tcnt        <= '0;
                    bcnt        <= '0;
                end
                WAIT_START: if (clk_en_i) begin
                    if (!cmd_i) begin
                        bcnt <= long_q ? CntWidth'(135) : CntWidth'(47);
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        if (timeout_hit) timeout_q <= 1'b1;
                    end
                end
                SHIFT: if (clk_en_i) begin
                    frame <= {frame[FrameW-2:0], cmd_i};
                    bcnt  <= bcnt - 1'b1;
                    if (crc_en) crc <= {crc[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
                end
                default: ;
            endcase
        end
    end

    // Output decode; everything except busy is gated to zero outside DONE.
    always_comb begin
        busy_o        = (state != IDLE);
        rsp_valid_o   = (state == DONE);
        rsp_o         = '0;
        index_o       = '0;
        timeout_err_o = 1'b0;
        crc_err_o     = 1'b0;
        frame_err_o   = 1'b0;
        if (state == DONE) begin
            if (timeout_q) begin
                timeout_err_o = 1'b1;
            end else begin
                crc_err_o = check_crc_q && (crc != frame[7:1]);
`ifdef SDHCI_RSP_LONG_EN
                if (long_q) begin
                    rsp_o       = {frame[127:1], 1'b0};
                    frame_err_o = !frame[0];
                end else begin
                    rsp_o       = {96'b0, frame[39:8]};
                    index_o     = frame[45:40];
                    frame_err_o = !frame[0] || frame[46];
                end
`else
                rsp_o       = {96'b0, frame[39:8]};
                index_o     = frame[45:40];
                frame_err_o = !frame[0] || frame[46];
`endif
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_rsp_rx.sv
// Directed self-checking bench for sd_cmd_rsp_rx.
module tb_sd_cmd_rsp_rx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clk_en;
    logic         start;
    logic         long_sel;
    logic         check_crc;
    logic         abort;
    logic         cmd;
    logic         busy;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp;
    logic [5:0]   index;
    logic         timeout_err;
    logic         crc_err;
    logic         frame_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    localparam logic [47:0]  FrmGood   = 48'h08000001AA13;
    localparam logic [47:0]  FrmCrcBad = 48'h08000001AA1B;
    localparam logic [47:0]  FrmTxBad  = 48'h400000000095;
    localparam logic [47:0]  FrmEndBad = 48'h08000001AA12;
    localparam logic [135:0] FrmLong   = {8'h3F, 120'hA5, 8'hBD};

    always #5 clk = ~clk;

    sd_cmd_rsp_rx #(.TimeoutCycles(64), .CntWidth(8)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clk_en_i      (clk_en),
        .start_i       (start),
        .long_i        (long_sel),
        .check_crc_i   (check_crc),
        .abort_i       (abort),
        .cmd_i         (cmd),
        .busy_o        (busy),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_o         (rsp),
        .index_o       (index),
        .timeout_err_o (timeout_err),
        .crc_err_o     (crc_err),
        .frame_err_o   (frame_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic is_long, input logic crc_on);
        start     = 1'b1;
        long_sel  = is_long;
        check_crc = crc_on;
        tick();
        start     = 1'b0;
        long_sel  = 1'b0;
    endtask

    // Sends v[n-1:0] MSb first; with gap set, a dead cycle (strobe low,
    // inverted CMD) follows every bit.
    task automatic send_bits(input logic [135:0] v, input int unsigned n, input logic gap);
        for (int unsigned i = n; i > 0; i--) begin
            cmd    = v[i-1];
            clk_en = 1'b1;
            tick();
            if (gap) begin
                clk_en = 1'b0;
                cmd    = ~v[i-1];
                tick();
            end
        end
        clk_en = 1'b0;
        cmd    = 1'b1;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [127:0] r, input logic [5:0] idx,
                              input logic to, input logic ce, input logic fe);
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_rsp"}, rsp, r);
        check({tag, "_index"}, index, idx);
        check({tag, "_timeout"}, timeout_err, to);
        check({tag, "_crc"}, crc_err, ce);
        check({tag, "_frame"}, frame_err, fe);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; clk_en = 1'b0; start = 1'b0; long_sel = 1'b0; check_crc = 1'b0;
        abort = 1'b0; cmd = 1'b1; rsp_ready = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_valid", rsp_valid, 0);
        check("reset_rsp", rsp, 0);
        check("reset_flags", {index, timeout_err, crc_err, frame_err}, 0);
        #22 rst_n = 1'b1;
        tick();

        // Good short frame with idle strobes and strobe gaps.
        arm(1'b0, 1'b1);
        check("armed_busy", busy, 1);
        send_bits(136'h1F, 5, 1'b0);
        send_bits({88'b0, FrmGood}, 48, 1'b1);
        expect_rsp("short", 128'h1AA, 6'd8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cmd    = i[0];
            clk_en = i[1];
            tick();
            check("hold_valid", rsp_valid, 1);
            check("hold_rsp", rsp, 128'h1AA);
            check("hold_index", index, 8);
        end
        clk_en = 1'b0;
        ack();
        check("ack_valid", rsp_valid, 0);
        check("ack_busy", busy, 0);

        // CRC error, then same frame with checking disabled.
        arm(1'b0, 1'b1);
        send_bits({88'b0, FrmCrcBad}, 48, 1'b0);
        expect_rsp("crcbad", 128'h1AA, 6'd8, 1'b0, 1'b1, 1'b0);
        ack();
        arm(1'b0, 1'b0);
        send_bits({88'b0, FrmCrcBad}, 48, 1'b0);
        expect_rsp("crcoff", 128'h1AA, 6'd8, 1'b0, 1'b0, 1'b0);
        ack();

        // Transmission bit set, then end bit cleared.
        arm(1'b0, 1'b1);
        send_bits({88'b0, FrmTxBad}, 48, 1'b0);
        expect_rsp("txbit", 128'h0, 6'd0, 1'b0, 1'b0, 1'b1);
        ack();
        arm(1'b0, 1'b1);
        send_bits({88'b0, FrmEndBad}, 48, 1'b0);
        expect_rsp("endbit", 128'h1AA, 6'd8, 1'b0, 1'b0, 1'b1);
        ack();

        // Timeout after 64 idle strobes (gapped strobes must not count twice).
        arm(1'b0, 1'b1);
        send_bits({136{1'b1}}, 63, 1'b1);
        check("to_63_valid", rsp_valid, 0);
        check("to_63_busy", busy, 1);
        send_bits({136{1'b1}}, 1, 1'b0);
        expect_rsp("timeout", 128'h0, 6'd0, 1'b1, 1'b0, 1'b0);
        ack();

        // Start bit on strobe 64 wins over timeout.
        arm(1'b0, 1'b1);
        send_bits({136{1'b1}}, 63, 1'b0);
        send_bits({88'b0, FrmGood}, 48, 1'b0);
        expect_rsp("late_start", 128'h1AA, 6'd8, 1'b0, 1'b0, 1'b0);

        // start_i during the DONE->IDLE handoff is ignored.
        start     = 1'b1;
        rsp_ready = 1'b1;
        tick();
        start     = 1'b0;
        rsp_ready = 1'b0;
        check("handoff_busy", busy, 0);
        tick();
        check("handoff_stay_idle", busy, 0);

        // Long R2 frame.
        arm(1'b1, 1'b1);
        send_bits(FrmLong, 136, 1'b0);
`ifdef SDHCI_RSP_LONG_EN
        expect_rsp("long", 128'hA5BC, 6'd0, 1'b0, 1'b0, 1'b0);
`else
        check("long_as_short_valid", rsp_valid, 1);
        check("long_as_short_rsp", rsp, 0);
        check("long_as_short_index", index, 6'h3F);
        check("long_as_short_frame", frame_err, 1);
`endif
        ack();

        // Abort mid-SHIFT.
        arm(1'b0, 1'b1);
        send_bits({88'b0, FrmGood} >> 28, 20, 1'b0);
        check("pre_abort_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", rsp_valid, 0);
        send_bits({88'b0, FrmGood}, 28, 1'b0);
        check("abort_no_valid", rsp_valid, 0);

        // Asynchronous reset mid-SHIFT.
        arm(1'b0, 1'b1);
        send_bits({88'b0, FrmGood} >> 20, 28, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_rsp", rsp, 0);
        #3 rst_n = 1'b1;
        tick();
        arm(1'b0, 1'b1);
        send_bits({88'b0, FrmGood}, 48, 1'b0);
        expect_rsp("post_rst", 128'h1AA, 6'd8, 1'b0, 1'b0, 1'b0);
        ack();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
